control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) then execute (T3-T6) of one instruction.
// Latency: one state per clock; T1 repeats until mem_ready. All outputs are decoded from state and ir.
// Backpressure: only mem_ready can stall, and only in T1. run=0 stops at the next instruction boundary.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [13:0] ctrl,
    output logic [4:0]  opcode,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam int PC_OUT    = 0;
    localparam int MAR_IN    = 1;
    localparam int INC_PC    = 2;
    localparam int Z_IN      = 3;
    localparam int PC_IN     = 4;
    localparam int READ      = 5;
    localparam int MDR_IN    = 6;
    localparam int MDR_OUT   = 7;
    localparam int IR_IN     = 8;
    localparam int Y_IN      = 9;
    localparam int ZLOW_OUT  = 10;
    localparam int ZHIGH_OUT = 11;
    localparam int HI_IN     = 12;
    localparam int LO_IN     = 13;

    localparam logic [4:0] OP_ALU_LAST = 5'b01110;
    localparam logic [4:0] OP_MUL      = 5'b01111;
    localparam logic [4:0] OP_DIV      = 5'b10000;
    localparam logic [4:0] OP_NOP      = 5'b11010;
    localparam logic [4:0] OP_HALT     = 5'b11011;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [4:0] ir_op;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       is_alu, is_muldiv, is_nop, is_halt;
    logic       unused_ir_low;

    assign ir_op = ir[31:27];
    assign ir_ra = ir[26:23];
    assign ir_rb = ir[22:19];
    assign ir_rc = ir[18:15];
    assign unused_ir_low = ^ir[14:0];

    assign is_alu    = (ir_op <= OP_ALU_LAST);
    assign is_muldiv = (ir_op == OP_MUL) || (ir_op == OP_DIV);
    assign is_nop    = (ir_op == OP_NOP);
    assign is_halt   = (ir_op == OP_HALT);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        ctrl       = '0;
        opcode     = '0;
        Rin        = '0;
        Rout       = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                ctrl[PC_OUT] = 1'b1;
                ctrl[MAR_IN] = 1'b1;
                ctrl[INC_PC] = 1'b1;
                ctrl[Z_IN]   = 1'b1;
                state_d      = S_T1;
            end
            S_T1: begin
                // PC reloads only on the completing cycle so a long wait never double-loads it.
                ctrl[ZLOW_OUT] = 1'b1;
                ctrl[READ]     = 1'b1;
                ctrl[MDR_IN]   = 1'b1;
                if (mem_ready) begin
                    ctrl[PC_IN] = 1'b1;
                    state_d     = S_T2;
                end
            end
            S_T2: begin
                ctrl[MDR_OUT] = 1'b1;
                ctrl[IR_IN]   = 1'b1;
                if (is_nop) begin
                    instr_done = 1'b1;
                    state_d    = run ? S_T0 : S_IDLE;
                end else begin
                    state_d = S_T3;
                end
            end
            S_T3: begin
                Rout[ir_rb] = 1'b1;
                ctrl[Y_IN]  = 1'b1;
                if (is_halt) begin
                    illegal_d = 1'b0;
                    state_d   = S_HALT;
                end else if (!(is_alu || is_muldiv)) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: begin
                Rout[ir_rc] = 1'b1;
                ctrl[Z_IN]  = 1'b1;
                opcode      = ir_op;
                state_d     = S_T5;
            end
            S_T5: begin
                ctrl[ZLOW_OUT] = 1'b1;
                if (is_muldiv) begin
                    ctrl[LO_IN] = 1'b1;
                    state_d     = S_T6;
                end else begin
                    Rin[ir_ra] = 1'b1;
                    instr_done = 1'b1;
                    state_d    = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                ctrl[ZHIGH_OUT] = 1'b1;
                ctrl[HI_IN]     = 1'b1;
                instr_done      = 1'b1;
                state_d         = run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                halted  = 1'b1;
                illegal = illegal_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
